// File: rtl/falafel_mem_arbiter_if.sv
// Request/response bundle for the requesters, the arbiter and the shared memory port.
// The arbiter uses the slave view; the requesters and memory use the master view.
interface falafel_mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]             req_val_i;
  logic [NUM_REQ-1:0]             req_rdy_o;
  logic [NUM_REQ-1:0]             req_is_write_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]             rsp_val_o;
  logic [NUM_REQ-1:0]             rsp_rdy_i;
  logic [DATA_W-1:0]              rsp_data_o;
  logic                           mem_req_rdy_i;
  logic                           mem_req_val_o;
  logic                           mem_req_is_write_o;
  logic [DATA_W-1:0]              mem_req_addr_o;
  logic [DATA_W-1:0]              mem_req_data_o;
  logic                           mem_rsp_val_i;
  logic                           mem_rsp_rdy_o;
  logic [DATA_W-1:0]              mem_rsp_data_i;

  modport slave (
    input  req_val_i, req_is_write_i, req_addr_i, req_data_i, rsp_rdy_i,
    input  mem_req_rdy_i, mem_rsp_val_i, mem_rsp_data_i,
    output req_rdy_o, rsp_val_o, rsp_data_o,
    output mem_req_val_o, mem_req_is_write_o, mem_req_addr_o, mem_req_data_o, mem_rsp_rdy_o
  );

  modport master (
    output req_val_i, req_is_write_i, req_addr_i, req_data_i, rsp_rdy_i,
    output mem_req_rdy_i, mem_rsp_val_i, mem_rsp_data_i,
    input  req_rdy_o, rsp_val_o, rsp_data_o,
    input  mem_req_val_o, mem_req_is_write_o, mem_req_addr_o, mem_req_data_o, mem_rsp_rdy_o
  );
endinterface

// File: rtl/falafel_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters; read
// responses are routed back in order through a FIFO of requester indices.
module falafel_mem_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  falafel_mem_arbiter_if.slave bus
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TAG_W-1:0] LAST_REQ  = TAG_W'(NUM_REQ - 1);
  localparam logic [TAG_W:0]   NUM_REQ_W = (TAG_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [0:0]       ST_ARB    = 1'b0;
  localparam logic [0:0]       ST_LOCK   = 1'b1;

  logic [0:0]       state_reg;
  logic [TAG_W-1:0] rr_ptr_reg;
  logic [TAG_W-1:0] grant_reg;
  logic             quiet_reg;
  logic [TAG_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic [NUM_REQ-1:0] elig;
  logic [TAG_W-1:0]   sel;
  logic [TAG_W-1:0]   cur;
  logic [TAG_W-1:0]   rr_next;
  logic [TAG_W-1:0]   head;
  logic               any_elig;
  logic               gate;
  logic               req_go;
  logic               hs;
  logic               push;
  logic               pop;
  logic               tag_full;
  logic               tag_empty;

  // Outputs stay silent during reset and for one cycle after it.
  assign gate      = !rst_ni || quiet_reg;
  assign tag_full  = (count_reg == FULL_CNT);
  assign tag_empty = (count_reg == '0);
  assign head      = tag_mem[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign elig[gi] = bus.req_val_i[gi] && (bus.req_is_write_i[gi] || !tag_full);
    end
  endgenerate

  always_comb begin
    logic [TAG_W:0] cand;
    sel      = rr_ptr_reg;
    any_elig = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (TAG_W + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!any_elig && elig[cand[TAG_W-1:0]]) begin
        any_elig = 1'b1;
        sel      = cand[TAG_W-1:0];
      end
    end
  end

  assign cur     = (state_reg == ST_LOCK) ? grant_reg : sel;
  assign rr_next = (cur == LAST_REQ) ? '0 : cur + TAG_W'(1);
  assign req_go  = !gate && ((state_reg == ST_LOCK) ? bus.req_val_i[cur] : any_elig);
  assign hs      = req_go && bus.mem_req_rdy_i;
  assign push    = hs && !bus.req_is_write_i[cur];
  assign pop     = bus.mem_rsp_val_i && bus.mem_rsp_rdy_o;

  always_comb begin
    bus.req_rdy_o          = '0;
    bus.rsp_val_o          = '0;
    bus.rsp_data_o         = '0;
    bus.mem_req_val_o      = 1'b0;
    bus.mem_req_is_write_o = 1'b0;
    bus.mem_req_addr_o     = '0;
    bus.mem_req_data_o     = '0;
    bus.mem_rsp_rdy_o      = 1'b0;
    if (!gate) begin
      bus.mem_req_val_o      = req_go;
      bus.mem_req_is_write_o = bus.req_is_write_i[cur];
      bus.mem_req_addr_o     = bus.req_addr_i[cur];
      bus.mem_req_data_o     = bus.req_data_i[cur];
      bus.req_rdy_o[cur]     = hs;
      bus.rsp_val_o[head]    = bus.mem_rsp_val_i && !tag_empty;
      bus.rsp_data_o         = bus.mem_rsp_data_i;
      bus.mem_rsp_rdy_o      = !tag_empty && bus.rsp_rdy_i[head];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg  <= ST_ARB;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      quiet_reg  <= 1'b1;
    end else begin
      quiet_reg <= 1'b0;
      if (hs) begin
        rr_ptr_reg <= rr_next;
        state_reg  <= ST_ARB;
      end else if (state_reg == ST_ARB && req_go) begin
        grant_reg <= sel;
        state_reg <= ST_LOCK;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr_reg] <= cur;
  end

`ifndef SYNTHESIS
  // A locked requester must keep its request up until memory takes it.
  a_lock_hold: assert property (@(posedge clk_i) disable iff (gate)
    (state_reg == ST_LOCK) |-> bus.req_val_i[grant_reg]);
  a_rsp_has_tag: assert property (@(posedge clk_i) disable iff (gate)
    bus.mem_rsp_val_i |-> !tag_empty);
`endif
endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// Directed bench for falafel_mem_arbiter: reset, read path, round-robin, lock,
// tag-full back-pressure, response ordering and reset in the middle of a lock.
module tb_falafel_mem_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  falafel_mem_arbiter_if #(.NUM_REQ(2), .DATA_W(64)) bus ();

  falafel_mem_arbiter #(.NUM_REQ(2), .DATA_W(64), .MAX_OUTSTANDING(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_val_i      = '0;
    bus.req_is_write_i = '0;
    bus.rsp_rdy_i      = '0;
    bus.mem_req_rdy_i  = 1'b0;
    bus.mem_rsp_val_i  = 1'b0;
    bus.mem_rsp_data_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.req_addr_i[0] = 64'h100;
    bus.req_addr_i[1] = 64'h200;
    bus.req_data_i[0] = 64'h11;
    bus.req_data_i[1] = 64'h22;
    bus.req_val_i      = 2'b11;
    bus.mem_req_rdy_i  = 1'b1;
    bus.mem_rsp_val_i  = 1'b1;
    bus.mem_rsp_data_i = 64'h1234;
    bus.rsp_rdy_i      = 2'b11;
    for (int p = 0; p < 2; p++) begin
      cyc();
      if (p == 1) rst_n = 1'b1;
      mid();
      checks++;
      if (bus.mem_req_val_o !== 1'b0 || bus.req_rdy_o !== 2'b00) begin
        errors++;
        $display("FAIL reset_req phase %0d got val=%b rdy=%b exp val=0 rdy=00", p, bus.mem_req_val_o, bus.req_rdy_o);
      end
      checks++;
      if (bus.rsp_val_o !== 2'b00 || bus.mem_rsp_rdy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_rsp phase %0d got rsp_val=%b mem_rsp_rdy=%b exp 00/0", p, bus.rsp_val_o, bus.mem_rsp_rdy_o);
      end
      checks++;
      if (bus.mem_req_addr_o !== 64'h0 || bus.mem_req_data_o !== 64'h0 || bus.rsp_data_o !== 64'h0) begin
        errors++;
        $display("FAIL reset_data phase %0d got addr=%h data=%h rsp=%h exp 0", p, bus.mem_req_addr_o, bus.mem_req_data_o, bus.rsp_data_o);
      end
    end
    cyc();
    idle();
  endtask

  task automatic test_single_read();
    bus.req_val_i     = 2'b01;
    bus.req_addr_i[0] = 64'h100;
    bus.mem_req_rdy_i = 1'b1;
    mid();
    checks++;
    if (bus.mem_req_val_o !== 1'b1 || bus.mem_req_addr_o !== 64'h100 || bus.mem_req_is_write_o !== 1'b0) begin
      errors++;
      $display("FAIL single_req got val=%b addr=%h wr=%b exp 1/100/0", bus.mem_req_val_o, bus.mem_req_addr_o, bus.mem_req_is_write_o);
    end
    checks++;
    if (bus.req_rdy_o !== 2'b01) begin
      errors++;
      $display("FAIL single_rdy got %b exp 01", bus.req_rdy_o);
    end
    cyc();
    idle();
    mid();
    checks++;
    if (bus.rsp_val_o !== 2'b00) begin
      errors++;
      $display("FAIL single_norsp got %b exp 00", bus.rsp_val_o);
    end
    cyc();
    bus.mem_rsp_val_i  = 1'b1;
    bus.mem_rsp_data_i = 64'hDEAD;
    bus.rsp_rdy_i      = 2'b11;
    mid();
    checks++;
    if (bus.rsp_val_o !== 2'b01 || bus.rsp_data_o !== 64'hDEAD || bus.mem_rsp_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp got val=%b data=%h rdy=%b exp 01/dead/1", bus.rsp_val_o, bus.rsp_data_o, bus.mem_rsp_rdy_o);
    end
    cyc();
    idle();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [63:0] exp_addr;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.req_val_i     = 2'b11;
    bus.req_addr_i[0] = 64'h10;
    bus.req_addr_i[1] = 64'h20;
    bus.mem_req_rdy_i = 1'b1;
    exp_rdy = 2'b01;
    for (int c = 0; c < 4; c++) begin
      exp_addr = exp_rdy[0] ? 64'h10 : 64'h20;
      mid();
      checks++;
      if (bus.req_rdy_o !== exp_rdy || bus.mem_req_addr_o !== exp_addr) begin
        errors++;
        $display("FAIL rr_grant%0d got rdy=%b addr=%h exp rdy=%b addr=%h", c, bus.req_rdy_o, bus.mem_req_addr_o, exp_rdy, exp_addr);
      end
      cyc();
      exp_rdy = {exp_rdy[0], exp_rdy[1]};
    end
    idle();
    bus.mem_rsp_val_i = 1'b1;
    bus.rsp_rdy_i     = 2'b11;
    exp_rdy = 2'b01;
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++;
      if (bus.rsp_val_o !== exp_rdy || bus.mem_rsp_rdy_o !== 1'b1) begin
        errors++;
        $display("FAIL rr_rsp%0d got val=%b rdy=%b exp val=%b rdy=1", c, bus.rsp_val_o, bus.mem_rsp_rdy_o, exp_rdy);
      end
      cyc();
      exp_rdy = {exp_rdy[0], exp_rdy[1]};
    end
    idle();
  endtask

  task automatic test_lock();
    bus.req_val_i      = 2'b01;
    bus.req_is_write_i = 2'b01;
    bus.req_addr_i[0]  = 64'h40;
    bus.req_data_i[0]  = 64'h55;
    bus.req_addr_i[1]  = 64'h80;
    for (int c = 0; c < 3; c++) begin
      mid();
      checks++;
      if (bus.mem_req_val_o !== 1'b1 || bus.mem_req_addr_o !== 64'h40 || bus.mem_req_is_write_o !== 1'b1 ||
          bus.mem_req_data_o !== 64'h55 || bus.req_rdy_o !== 2'b00) begin
        errors++;
        $display("FAIL lock_hold%0d got val=%b addr=%h wr=%b data=%h rdy=%b exp 1/40/1/55/00", c,
                 bus.mem_req_val_o, bus.mem_req_addr_o, bus.mem_req_is_write_o, bus.mem_req_data_o, bus.req_rdy_o);
      end
      cyc();
      bus.req_val_i = 2'b11;
    end
    bus.mem_req_rdy_i = 1'b1;
    mid();
    checks++;
    if (bus.req_rdy_o !== 2'b01 || bus.mem_req_addr_o !== 64'h40) begin
      errors++;
      $display("FAIL lock_release got rdy=%b addr=%h exp 01/40", bus.req_rdy_o, bus.mem_req_addr_o);
    end
    cyc();
    bus.req_addr_i[0] = 64'h44;
    mid();
    checks++;
    if (bus.req_rdy_o !== 2'b10 || bus.mem_req_addr_o !== 64'h80 || bus.mem_req_is_write_o !== 1'b0) begin
      errors++;
      $display("FAIL lock_next got rdy=%b addr=%h wr=%b exp 10/80/0", bus.req_rdy_o, bus.mem_req_addr_o, bus.mem_req_is_write_o);
    end
    cyc();
    idle();
    bus.mem_rsp_val_i  = 1'b1;
    bus.mem_rsp_data_i = 64'h77;
    bus.rsp_rdy_i      = 2'b11;
    mid();
    checks++;
    if (bus.rsp_val_o !== 2'b10 || bus.rsp_data_o !== 64'h77) begin
      errors++;
      $display("FAIL lock_rsp got val=%b data=%h exp 10/77", bus.rsp_val_o, bus.rsp_data_o);
    end
    cyc();
    idle();
  endtask

  task automatic test_tag_full();
    logic [1:0] exp_tags [4];
    exp_tags = '{2'b10, 2'b10, 2'b10, 2'b01};
    bus.req_val_i     = 2'b10;
    bus.req_addr_i[1] = 64'h300;
    bus.mem_req_rdy_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++;
      if (bus.req_rdy_o !== 2'b10) begin
        errors++;
        $display("FAIL full_fill%0d got %b exp 10", c, bus.req_rdy_o);
      end
      cyc();
    end
    bus.req_val_i     = 2'b01;
    bus.req_addr_i[0] = 64'h500;
    mid();
    checks++;
    if (bus.mem_req_val_o !== 1'b0 || bus.req_rdy_o !== 2'b00) begin
      errors++;
      $display("FAIL full_block got val=%b rdy=%b exp 0/00", bus.mem_req_val_o, bus.req_rdy_o);
    end
    cyc();
    bus.req_is_write_i = 2'b01;
    mid();
    checks++;
    if (bus.mem_req_val_o !== 1'b1 || bus.req_rdy_o !== 2'b01 || bus.mem_req_is_write_o !== 1'b1) begin
      errors++;
      $display("FAIL full_write got val=%b rdy=%b wr=%b exp 1/01/1", bus.mem_req_val_o, bus.req_rdy_o, bus.mem_req_is_write_o);
    end
    cyc();
    bus.req_is_write_i = 2'b00;
    bus.mem_rsp_val_i  = 1'b1;
    bus.mem_rsp_data_i = 64'h1;
    bus.rsp_rdy_i      = 2'b11;
    mid();
    checks++;
    if (bus.req_rdy_o !== 2'b00 || bus.rsp_val_o !== 2'b10 || bus.mem_rsp_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL full_samepop got rdy=%b rsp=%b mrdy=%b exp 00/10/1", bus.req_rdy_o, bus.rsp_val_o, bus.mem_rsp_rdy_o);
    end
    cyc();
    bus.mem_rsp_val_i = 1'b0;
    mid();
    checks++;
    if (bus.req_rdy_o !== 2'b01 || bus.mem_req_addr_o !== 64'h500) begin
      errors++;
      $display("FAIL full_freed got rdy=%b addr=%h exp 01/500", bus.req_rdy_o, bus.mem_req_addr_o);
    end
    cyc();
    idle();
    bus.mem_rsp_val_i = 1'b1;
    bus.rsp_rdy_i     = 2'b11;
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++;
      if (bus.rsp_val_o !== exp_tags[c]) begin
        errors++;
        $display("FAIL full_drain%0d got %b exp %b", c, bus.rsp_val_o, exp_tags[c]);
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_ordering();
    bus.req_val_i     = 2'b01;
    bus.req_addr_i[0] = 64'h600;
    bus.req_addr_i[1] = 64'h700;
    bus.mem_req_rdy_i = 1'b1;
    mid();
    checks++;
    if (bus.req_rdy_o !== 2'b01) begin
      errors++;
      $display("FAIL order_req0 got %b exp 01", bus.req_rdy_o);
    end
    cyc();
    bus.req_val_i = 2'b10;
    mid();
    checks++;
    if (bus.req_rdy_o !== 2'b10) begin
      errors++;
      $display("FAIL order_req1 got %b exp 10", bus.req_rdy_o);
    end
    cyc();
    idle();
    bus.mem_rsp_val_i  = 1'b1;
    bus.mem_rsp_data_i = 64'hA;
    bus.rsp_rdy_i      = 2'b10;
    for (int c = 0; c < 2; c++) begin
      mid();
      checks++;
      if (bus.mem_rsp_rdy_o !== 1'b0 || bus.rsp_val_o !== 2'b01 || bus.rsp_data_o !== 64'hA) begin
        errors++;
        $display("FAIL order_stall%0d got mrdy=%b val=%b data=%h exp 0/01/a", c, bus.mem_rsp_rdy_o, bus.rsp_val_o, bus.rsp_data_o);
      end
      cyc();
    end
    bus.rsp_rdy_i = 2'b11;
    mid();
    checks++;
    if (bus.mem_rsp_rdy_o !== 1'b1 || bus.rsp_val_o !== 2'b01) begin
      errors++;
      $display("FAIL order_first got mrdy=%b val=%b exp 1/01", bus.mem_rsp_rdy_o, bus.rsp_val_o);
    end
    cyc();
    bus.mem_rsp_data_i = 64'hB;
    mid();
    checks++;
    if (bus.mem_rsp_rdy_o !== 1'b1 || bus.rsp_val_o !== 2'b10 || bus.rsp_data_o !== 64'hB) begin
      errors++;
      $display("FAIL order_second got mrdy=%b val=%b data=%h exp 1/10/b", bus.mem_rsp_rdy_o, bus.rsp_val_o, bus.rsp_data_o);
    end
    cyc();
    idle();
    mid();
    checks++;
    if (bus.rsp_val_o !== 2'b00) begin
      errors++;
      $display("FAIL order_done got %b exp 00", bus.rsp_val_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid_lock();
    bus.req_val_i     = 2'b11;
    bus.req_addr_i[0] = 64'h800;
    bus.req_addr_i[1] = 64'h900;
    bus.mem_req_rdy_i = 1'b1;
    cyc();
    cyc();
    bus.req_val_i     = 2'b01;
    bus.mem_req_rdy_i = 1'b0;
    cyc();
    mid();
    checks++;
    if (bus.mem_req_val_o !== 1'b1 || bus.mem_req_addr_o !== 64'h800 || bus.req_rdy_o !== 2'b00) begin
      errors++;
      $display("FAIL mrst_locked got val=%b addr=%h rdy=%b exp 1/800/00", bus.mem_req_val_o, bus.mem_req_addr_o, bus.req_rdy_o);
    end
    cyc();
    rst_n              = 1'b0;
    bus.mem_rsp_val_i  = 1'b1;
    bus.mem_rsp_data_i = 64'hBAD;
    bus.rsp_rdy_i      = 2'b11;
    for (int p = 0; p < 2; p++) begin
      mid();
      checks++;
      if (bus.mem_req_val_o !== 1'b0 || bus.req_rdy_o !== 2'b00 || bus.mem_req_addr_o !== 64'h0 ||
          bus.rsp_val_o !== 2'b00 || bus.mem_rsp_rdy_o !== 1'b0 || bus.rsp_data_o !== 64'h0) begin
        errors++;
        $display("FAIL mrst_quiet%0d got val=%b rdy=%b addr=%h rsp=%b mrdy=%b data=%h exp all 0", p,
                 bus.mem_req_val_o, bus.req_rdy_o, bus.mem_req_addr_o, bus.rsp_val_o, bus.mem_rsp_rdy_o, bus.rsp_data_o);
      end
      cyc();
      rst_n = 1'b1;
    end
    bus.mem_rsp_val_i = 1'b0;
    bus.mem_req_rdy_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mid();
      checks++;
      if (bus.req_rdy_o !== ((c < 4) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL mrst_refill%0d got %b exp %b", c, bus.req_rdy_o, (c < 4) ? 2'b01 : 2'b00);
      end
      cyc();
    end
    idle();
    bus.mem_rsp_val_i = 1'b1;
    bus.rsp_rdy_i     = 2'b11;
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++;
      if (bus.rsp_val_o !== 2'b01) begin
        errors++;
        $display("FAIL mrst_drain%0d got %b exp 01", c, bus.rsp_val_o);
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_addr_i = '0;
    bus.req_data_i = '0;
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_tag_full();
    test_ordering();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
